// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, size encodings and alignment helper for the memory bus arbiter
package mem_arb_pkg;

    // Transaction phases of the single shared memory port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // Access size encodings (log2 of the byte count)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Cycles spent waiting for a downstream response before an error is forced
    localparam int DEF_TIMEOUT = 1024;

    // An access is misaligned when any address bit below its natural size is set
    function automatic logic is_misaligned(input logic [2:0] addr_lsb, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lsb[0];
            SZ_W:    mis = |addr_lsb[1:0];
            SZ_D:    mis = |addr_lsb;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and downstream memory bus signals of the arbiter
interface mem_bus_arbiter_if;

    // Requester 0: I-cache refill path
    logic        m0_req_valid;
    logic        m0_req_ready;
    logic [63:0] m0_req_addr;
    logic        m0_req_we;
    logic [1:0]  m0_req_size;
    logic [63:0] m0_req_wdata;
    logic        m0_resp_valid;
    logic [63:0] m0_resp_rdata;
    logic        m0_resp_err;

    // Requester 1: D-cache / LSU path
    logic        m1_req_valid;
    logic        m1_req_ready;
    logic [63:0] m1_req_addr;
    logic        m1_req_we;
    logic [1:0]  m1_req_size;
    logic [63:0] m1_req_wdata;
    logic        m1_resp_valid;
    logic [63:0] m1_resp_rdata;
    logic        m1_resp_err;

    // Downstream data-memory port
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [1:0]  mem_req_size;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    // Arbiter side
    modport slave (
        input  m0_req_valid, m0_req_addr, m0_req_we, m0_req_size, m0_req_wdata,
        output m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
        input  m1_req_valid, m1_req_addr, m1_req_we, m1_req_size, m1_req_wdata,
        output m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_size, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    // Requesters plus memory model side
    modport master (
        output m0_req_valid, m0_req_addr, m0_req_we, m0_req_size, m0_req_wdata,
        input  m0_req_ready, m0_resp_valid, m0_resp_rdata, m0_resp_err,
        output m1_req_valid, m1_req_addr, m1_req_we, m1_req_size, m1_req_wdata,
        input  m1_req_ready, m1_resp_valid, m1_resp_rdata, m1_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_size, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin picker producing a one-hot grant
module mem_arb_rr (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone requester wins outright; on a tie the one not served last wins
    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one 64-bit memory port between two requesters
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;

    localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [63:0]      r_addr;
    logic             r_we;
    logic [1:0]       r_size;
    logic [63:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [63:0]      r_resp_rdata;

    logic [1:0]       w_valid;
    logic [1:0]       w_grant;
    logic [1:0]       w_ready;
    logic             w_accept;
    logic             w_misaligned;
    logic             w_issue_done;
    logic             w_timeout;
    logic [63:0]      w_sel_addr;
    logic             w_sel_we;
    logic [1:0]       w_sel_size;
    logic [63:0]      w_sel_wdata;

    assign w_valid = {bus.m1_req_valid, bus.m0_req_valid};

    mem_arb_rr u_rr (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready is offered only in IDLE and never while reset is held
    assign w_ready  = (r_state == S_IDLE && rst) ? w_grant : 2'b00;
    assign w_accept = |w_ready;

    // Route the winning requester's fields toward the request latch
    always_comb begin
        w_sel_addr  = bus.m0_req_addr;
        w_sel_we    = bus.m0_req_we;
        w_sel_size  = bus.m0_req_size;
        w_sel_wdata = bus.m0_req_wdata;
        if (w_grant[1]) begin
            w_sel_addr  = bus.m1_req_addr;
            w_sel_we    = bus.m1_req_we;
            w_sel_size  = bus.m1_req_size;
            w_sel_wdata = bus.m1_req_wdata;
        end
    end

    assign w_misaligned = is_misaligned(w_sel_addr[2:0], w_sel_size);
    assign w_issue_done = (r_state == S_ISSUE) && bus.mem_req_ready;
    assign w_timeout    = (r_state == S_WAIT) && (r_cnt == CNT_MAX);

    // Transaction phase: misaligned requests never leave IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_misaligned) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture the accepted request and remember who owns it for fairness and routing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant[1];
            r_owner      <= w_grant[1];
            r_addr       <= w_sel_addr;
            r_we         <= w_sel_we;
            r_size       <= w_sel_size;
            r_wdata      <= w_sel_wdata;
        end
    end

    // WAIT-state cycle counter, restarted when the downstream accepts the request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_issue_done) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle response pulse; a real response beats a coincident timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            if (w_accept && w_misaligned) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
            end else if (r_state == S_WAIT) begin
                if (bus.mem_resp_valid) begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_we ? 64'd0 : bus.mem_resp_rdata;
                end else if (w_timeout) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.m0_req_ready   = w_ready[0];
    assign bus.m1_req_ready   = w_ready[1];

    assign bus.m0_resp_valid  = r_resp_valid & ~r_owner;
    assign bus.m0_resp_err    = r_resp_err & ~r_owner;
    assign bus.m0_resp_rdata  = r_owner ? 64'd0 : r_resp_rdata;
    assign bus.m1_resp_valid  = r_resp_valid & r_owner;
    assign bus.m1_resp_err    = r_resp_err & r_owner;
    assign bus.m1_resp_rdata  = r_owner ? r_resp_rdata : 64'd0;

    assign bus.mem_req_valid  = (r_state == S_ISSUE);
    assign bus.mem_req_addr   = r_addr;
    assign bus.mem_req_we     = r_we;
    assign bus.mem_req_size   = r_size;
    assign bus.mem_req_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int TMO = 8;
    localparam int WIN = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          m;
        logic [63:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [63:0] wdata;
        int          rdy;
        int          rsp;
        logic [63:0] mrd;
        int          e_cyc;
        logic        e_err;
        logic [63:0] e_rd;
        logic        e_iss;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.m0_req_valid = 1'b0; bus.m0_req_addr = '0; bus.m0_req_we = 1'b0;
        bus.m0_req_size = '0; bus.m0_req_wdata = '0;
        bus.m1_req_valid = 1'b0; bus.m1_req_addr = '0; bus.m1_req_we = 1'b0;
        bus.m1_req_size = '0; bus.m1_req_wdata = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    endtask

    task automatic drive_req(input int m, input logic v, input logic [63:0] a,
                             input logic we, input logic [1:0] sz, input logic [63:0] wd);
        if (m == 0) begin
            bus.m0_req_valid = v; bus.m0_req_addr = a; bus.m0_req_we = we;
            bus.m0_req_size = sz; bus.m0_req_wdata = wd;
        end else begin
            bus.m1_req_valid = v; bus.m1_req_addr = a; bus.m1_req_we = we;
            bus.m1_req_size = sz; bus.m1_req_wdata = wd;
        end
    endtask

    // Transaction-level reference: response cycle counted from the accept cycle
    function automatic void model(input logic [63:0] addr, input logic [1:0] size, input logic we,
                                  input int rdy, input int rsp, input logic [63:0] mrd,
                                  output int cyc, output logic err, output logic [63:0] rd,
                                  output logic iss);
        logic [63:0] bytes;
        int          h;
        bytes = 64'd1 << size;
        if ((addr % bytes) != 64'd0) begin
            cyc = 1; err = 1'b1; rd = '0; iss = 1'b0;
        end else begin
            iss = 1'b1;
            h = 1 + rdy;
            if (rsp >= 0 && rsp <= TMO - 1) begin
                cyc = h + rsp + 2; err = 1'b0; rd = we ? 64'd0 : mrd;
            end else begin
                cyc = h + TMO + 1; err = 1'b1; rd = '0;
            end
        end
    endfunction

    // Runs one transaction from an idle arbiter and checks it against the expectations in v
    task automatic run_txn(input string tag, input vec_t v);
        logic        acc = 1'b0;
        logic        iss = 1'b0;
        logic        err = 1'b0;
        logic [63:0] rd = '0;
        int          iss_cyc = 0;
        int          rc = -1;
        int          pulses = 0;
        int          other = 0;
        int          fbad = 0;
        logic        own_v, oth_v;
        idle_inputs();
        drive_req(v.m, 1'b1, v.addr, v.we, v.size, v.wdata);
        for (int w = 0; w < 8 && !acc; w++) begin
            @(negedge clk);
            acc = (v.m == 0) ? bus.m0_req_ready : bus.m1_req_ready;
            if (!acc) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        drive_req(v.m, 1'b0, ~v.addr, ~v.we, ~v.size, ~v.wdata);
        for (int c = 1; c <= WIN; c++) begin
            bus.mem_req_ready  = (c >= 1 + v.rdy);
            bus.mem_resp_valid = (v.rsp >= 0 && c == 2 + v.rdy + v.rsp);
            bus.mem_resp_rdata = bus.mem_resp_valid ? v.mrd : 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
            if (bus.mem_req_valid) begin
                if (!iss) begin
                    iss = 1'b1;
                    iss_cyc = c;
                end
                if (bus.mem_req_addr !== v.addr || bus.mem_req_we !== v.we ||
                    bus.mem_req_size !== v.size || bus.mem_req_wdata !== v.wdata) fbad++;
            end
            own_v = (v.m == 0) ? bus.m0_resp_valid : bus.m1_resp_valid;
            oth_v = (v.m == 0) ? bus.m1_resp_valid : bus.m0_resp_valid;
            if (own_v) begin
                pulses++;
                rc  = c;
                err = (v.m == 0) ? bus.m0_resp_err : bus.m1_resp_err;
                rd  = (v.m == 0) ? bus.m0_resp_rdata : bus.m1_resp_rdata;
            end
            if (oth_v) other++;
            @(posedge clk); #1;
        end
        idle_inputs();
        chk({tag, "_accepted"}, 64'(acc), 64'd1);
        chk({tag, "_resp_cycle"}, 64'(rc), 64'(v.e_cyc));
        chk({tag, "_resp_err"}, 64'(err), 64'(v.e_err));
        chk({tag, "_resp_rdata"}, rd, v.e_rd);
        chk({tag, "_pulse_count"}, 64'(pulses), 64'd1);
        chk({tag, "_nonowner_pulses"}, 64'(other), 64'd0);
        chk({tag, "_issued"}, 64'(iss), 64'(v.e_iss));
        chk({tag, "_issue_cycle"}, 64'(iss_cyc), v.e_iss ? 64'd1 : 64'd0);
        chk({tag, "_fields_stable"}, 64'(fbad), 64'd0);
    endtask

    // Both requesters valid back-to-back: grants must alternate starting with m0
    task automatic arb_test();
        int   grants[$];
        logic resp_at[$];
        int   resp_who[$];
        logic hs_prev = 1'b0;
        logic stop = 1'b0;
        int   tail = 0;
        idle_inputs();
        drive_req(0, 1'b1, 64'h100, 1'b0, 2'd3, 64'd0);
        drive_req(1, 1'b1, 64'h200, 1'b0, 2'd3, 64'd0);
        bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 60 && tail < 6; c++) begin
            bus.mem_resp_valid = hs_prev;
            bus.mem_resp_rdata = 64'h55;
            @(negedge clk);
            if (!stop) begin
                if (bus.m0_req_ready || bus.m1_req_ready) begin
                    grants.push_back(bus.m1_req_ready ? 1 : 0);
                    resp_at.push_back(bus.m0_resp_valid | bus.m1_resp_valid);
                    resp_who.push_back(bus.m1_resp_valid ? 1 : 0);
                end
            end
            hs_prev = bus.mem_req_valid & bus.mem_req_ready;
            @(posedge clk); #1;
            if (grants.size() >= 4 && !stop) begin
                stop = 1'b1;
                bus.m0_req_valid = 1'b0;
                bus.m1_req_valid = 1'b0;
            end
            if (stop) tail++;
        end
        idle_inputs();
        chk("arb_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
                chk($sformatf("arb_grant%0d", i), 64'(grants[i]), 64'(i % 2));
                if (i > 0) begin
                    chk($sformatf("arb_resp_same_cycle%0d", i), 64'(resp_at[i]), 64'd1);
                    chk($sformatf("arb_resp_owner%0d", i), 64'(resp_who[i]), 64'((i - 1) % 2));
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, "_mem_req_addr"}, bus.mem_req_addr, 64'd0);
        chk({tag, "_mem_req_we_size"}, 64'({bus.mem_req_we, bus.mem_req_size}), 64'd0);
        chk({tag, "_mem_req_wdata"}, bus.mem_req_wdata, 64'd0);
        chk({tag, "_resp_valid"}, 64'({bus.m0_resp_valid, bus.m1_resp_valid}), 64'd0);
        chk({tag, "_resp_err"}, 64'({bus.m0_resp_err, bus.m1_resp_err}), 64'd0);
        chk({tag, "_resp_rdata"}, bus.m0_resp_rdata | bus.m1_resp_rdata, 64'd0);
        chk({tag, "_req_ready"}, 64'({bus.m0_req_ready, bus.m1_req_ready}), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        vec_t rv;
        int   r;
        int   pulses;

        vecs[0]  = '{1, 64'h8000_0010, 1'b0, 2'd3, 64'h0, 0, 0, 64'h1122334455667788,
                     3, 1'b0, 64'h1122334455667788, 1'b1};
        vecs[1]  = '{1, 64'h8000_0002, 1'b1, 2'd2, 64'hCAFE, 0, 0, 64'h77,
                     1, 1'b1, 64'h0, 1'b0};
        vecs[2]  = '{0, 64'h1000, 1'b0, 2'd3, 64'h0, 5, 0, 64'hA5A5A5A5_5A5A5A5A,
                     8, 1'b0, 64'hA5A5A5A5_5A5A5A5A, 1'b1};
        vecs[3]  = '{0, 64'h2000, 1'b0, 2'd3, 64'h0, 0, -1, 64'h33,
                     10, 1'b1, 64'h0, 1'b1};
        vecs[4]  = '{0, 64'h2004, 1'b0, 2'd2, 64'h0, 0, 12, 64'h99,
                     10, 1'b1, 64'h0, 1'b1};
        vecs[5]  = '{1, 64'h3008, 1'b1, 2'd3, 64'h0123456789ABCDEF, 0, 2, 64'hDEAD,
                     5, 1'b0, 64'h0, 1'b1};
        vecs[6]  = '{0, 64'h4001, 1'b0, 2'd1, 64'h0, 0, 0, 64'h44,
                     1, 1'b1, 64'h0, 1'b0};
        vecs[7]  = '{0, 64'h5000, 1'b0, 2'd3, 64'h0, 0, 7, 64'h0F0F,
                     10, 1'b0, 64'h0F0F, 1'b1};
        vecs[8]  = '{0, 64'h7, 1'b0, 2'd0, 64'h0, 2, 1, 64'hAB,
                     6, 1'b0, 64'hAB, 1'b1};
        vecs[9]  = '{1, 64'h4, 1'b0, 2'd2, 64'h0, 1, 0, 64'h12345678,
                     4, 1'b0, 64'h12345678, 1'b1};
        vecs[10] = '{1, 64'h3C, 1'b0, 2'd3, 64'h0, 0, 0, 64'h66,
                     1, 1'b1, 64'h0, 1'b0};
        vecs[11] = '{0, 64'h6, 1'b1, 2'd1, 64'hBEEF, 3, 6, 64'hFFFF,
                     12, 1'b0, 64'h0, 1'b1};

        // Reset state, with both requesters already asking
        idle_inputs();
        bus.m0_req_valid = 1'b1;
        bus.m1_req_valid = 1'b1;
        #3;
        check_outputs_zero("reset");
        idle_inputs();
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        arb_test();

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 24; i++) begin
            rv.m    = $urandom_range(0, 1);
            rv.size = 2'($urandom_range(0, 3));
            rv.addr = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) rv.addr = rv.addr & ~(64'((1 << rv.size) - 1));
            rv.we    = 1'($urandom_range(0, 1));
            rv.wdata = {$urandom, $urandom};
            rv.rdy   = $urandom_range(0, 4);
            r        = $urandom_range(0, 13);
            rv.rsp   = (r == 13) ? -1 : r;
            rv.mrd   = {$urandom, $urandom};
            model(rv.addr, rv.size, rv.we, rv.rdy, rv.rsp, rv.mrd, rv.e_cyc, rv.e_err, rv.e_rd, rv.e_iss);
            run_txn($sformatf("rnd%0d", i), rv);
        end

        // Reset during WAIT aborts the transaction and restores the m0-first tie-break
        idle_inputs();
        drive_req(1, 1'b1, 64'h40, 1'b0, 2'd3, 64'h0);
        @(negedge clk);
        chk("rstwait_accept", 64'(bus.m1_req_ready), 64'd1);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 64'h0, 1'b0, 2'd0, 64'h0);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("rstwait");
        bus.m0_req_valid   = 1'b1;
        bus.m1_req_valid   = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 64'h1234;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.m0_resp_valid || bus.m1_resp_valid) pulses++;
        end
        chk("rstwait_no_pulse", 64'(pulses), 64'd0);
        bus.mem_resp_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_tie_m0", 64'({bus.m1_req_ready, bus.m0_req_ready}), 64'b01);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
